// File: rtl/control_unit_p_pkg.sv
// control_unit_p_pkg: control-word layout, next-state codes and helpers for the microprogrammed control unit
package control_unit_p_pkg;
  localparam int CTL_W = 34;
  localparam int N_HI = 57;
  localparam int N_LO = 55;
  localparam int INV_B = 54;
  localparam int MI_B = 53;
  localparam int S_HI = 52;
  localparam int S_LO = 50;
  localparam int CRA_HI = 49;
  localparam int CRA_LO = 42;
  localparam int CRB_HI = 41;
  localparam int CRB_LO = 34;
  localparam logic [CTL_W-1:0] C_FRLD = 34'h2_0000_0000;
  localparam logic [CTL_W-1:0] C_RFLD = 34'h1_0000_0000;
  localparam logic [CTL_W-1:0] C_IRLD = 34'h0_8000_0000;
  localparam logic [CTL_W-1:0] C_MARLD = 34'h0_4000_0000;
  localparam logic [CTL_W-1:0] C_MDRLD = 34'h0_2000_0000;
  localparam logic [CTL_W-1:0] C_RW = 34'h0_1000_0000;
  localparam logic [CTL_W-1:0] C_MOV = 34'h0_0800_0000;
  localparam int ST_DPS_IMM = 10;
  localparam int ST_DP_IMM = 11;
  localparam int ST_DPS_REG = 12;
  localparam int ST_LS_IMM = 16;
  localparam int ST_LS_REG = 17;
  localparam int ST_LSM = 20;
  localparam int ST_BR = 22;
  localparam int ST_UND = 31;
  typedef enum logic [2:0] {
    N_ENC = 3'b000, N_JMP = 3'b001, N_INC = 3'b010, N_STS_JI = 3'b011,
    N_STS_EI = 3'b100, N_STS_JE = 3'b101, N_RST = 3'b110, N_STS_IZ = 3'b111
  } n_e;
  typedef enum logic [1:0] {M_ENC, M_JMP, M_INC, M_ZERO} m_e;
  typedef enum logic [2:0] {S_MOC, S_COND, S_MLS0, S_MLS1, S_IR24, S_IR20, S_IR23, S_ONE} s_e;
  function automatic logic [7:0] encode(input logic [2:0] op, input logic b4, input logic b7);
    return (op == 3'b000 && !b4) ? 8'(ST_DPS_IMM) :
           (op == 3'b000 && !b7) ? 8'(ST_DPS_REG) :
           op == 3'b001 ? 8'(ST_DP_IMM) :
           op == 3'b010 ? 8'(ST_LS_IMM) :
           op == 3'b011 ? 8'(ST_LS_REG) :
           op == 3'b100 ? 8'(ST_LSM) :
           op == 3'b101 ? 8'(ST_BR) : 8'(ST_UND);
  endfunction
  function automatic m_e next_sel(input n_e n, input logic sts);
    case (n)
      N_ENC: return M_ENC;
      N_JMP: return M_JMP;
      N_INC: return M_INC;
      N_STS_JI: return sts ? M_JMP : M_INC;
      N_STS_EI: return sts ? M_ENC : M_INC;
      N_STS_JE: return sts ? M_JMP : M_ENC;
      N_RST: return M_ZERO;
      default: return sts ? M_INC : M_ZERO;
    endcase
  endfunction
  function automatic logic [63:0] uword(input n_e n, input logic inv, input logic mi, input s_e s,
                                        input logic [7:0] cr, input logic [CTL_W-1:0] ctl);
    return {6'd0, n, inv, mi, s, 8'd0, cr, ctl};
  endfunction
endpackage

// File: rtl/cu_microstore.sv
// cu_microstore: combinational microprogram ROM; unlisted addresses fall back to 0
module cu_microstore
  import control_unit_p_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [63:0]       word
);
  always_comb begin
    case (int'(addr))
      0: word = uword(N_INC, 1'b0, 1'b0, S_MOC, 8'd0, '0);
      1: word = uword(N_INC, 1'b0, 1'b0, S_MOC, 8'd0, C_MARLD);
      2: word = uword(N_INC, 1'b0, 1'b0, S_MOC, 8'd0, C_RW | C_MOV);
      3: word = uword(N_STS_JI, 1'b1, 1'b0, S_MOC, 8'd3, C_RW | C_MOV | C_MDRLD);
      4: word = uword(N_STS_EI, 1'b0, 1'b0, S_COND, 8'd0, C_IRLD);
      5: word = uword(N_JMP, 1'b0, 1'b0, S_MOC, 8'd1, '0);
      ST_DPS_IMM, ST_DP_IMM, ST_DPS_REG: word = uword(N_JMP, 1'b0, 1'b0, S_MOC, 8'd1, C_RFLD | C_FRLD);
      ST_LS_IMM, ST_LS_REG: word = uword(N_JMP, 1'b0, 1'b0, S_MOC, 8'd18, C_MARLD);
      18: word = uword(N_STS_JI, 1'b0, 1'b0, S_IR20, 8'd19, '0);
      19: word = uword(N_STS_JI, 1'b1, 1'b0, S_MOC, 8'd19, C_RW | C_MOV);
      ST_LSM: word = uword(N_JMP, 1'b0, 1'b0, S_MOC, 8'd1, C_RFLD);
      21: word = uword(N_STS_JI, 1'b1, 1'b0, S_MOC, 8'd21, C_MOV);
      ST_BR: word = uword(N_JMP, 1'b0, 1'b0, S_MOC, 8'd1, '0);
      23, 24: word = uword(N_JMP, 1'b0, 1'b0, S_MOC, 8'd1, C_RFLD);
      default: word = uword(N_RST, 1'b0, 1'b0, S_MOC, 8'd0, '0);
    endcase
  end
endmodule

// File: rtl/control_unit_p.sv
// control_unit_p: microprogrammed sequencer; control register reloads from the microstore every cycle
module control_unit_p
  import control_unit_p_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [31:0]      IR,
  input  logic             MOC,
  input  logic             COND,
  input  logic             MLS0,
  input  logic             MLS1,
  output logic [CTL_W-1:0] CTL
);
  logic [63:0] q, rom_word;
  logic [ADDR_W-1:0] incr, mux_a, mux_e, enc, addr;
  logic [7:0] status;
  logic sts, unused_bits;
  m_e m;
  assign status = {1'b1, IR[23], IR[20], IR[24], MLS1, MLS0, COND, MOC};
  assign sts = status[q[S_HI:S_LO]] ^ q[INV_B];
  assign m = next_sel(n_e'(q[N_HI:N_LO]), sts);
  assign enc = ADDR_W'(encode(IR[27:25], IR[4], IR[7]));
  assign mux_e = ADDR_W'(q[MI_B] ? q[CRA_HI:CRA_LO] : q[CRB_HI:CRB_LO]);
  always_comb mux_a = m == M_ENC ? enc : m == M_JMP ? mux_e : m == M_INC ? incr : '0;
  // Reset steers the ROM to address 0 so the register loads the idle word
  assign addr = RESET_N ? mux_a : '0;
  cu_microstore #(.ADDR_W(ADDR_W)) u_rom (.addr(addr), .word(rom_word));
  always_ff @(posedge CLK) begin
    q <= rom_word;
    incr <= RESET_N ? mux_a + 1'b1 : ADDR_W'(1);
  end
  assign CTL = q[CTL_W-1:0];
  assign unused_bits = ^{q[63:58], IR[31:28], IR[22:21], IR[19:8], IR[6:5], IR[3:0]};
endmodule

// File: tb/tb_control_unit_p.sv
// tb_control_unit_p: scoreboard bench comparing CTL against a state-transition model of the microprogram
module tb_control_unit_p;
  logic CLK = 1'b0, RESET_N = 1'b0, MOC = 1'b0, COND = 1'b0, MLS0 = 1'b0, MLS1 = 1'b0;
  logic [31:0] IR = '0;
  logic [33:0] CTL;
  typedef struct {
    int st;
    logic [33:0] ctl;
  } exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0, st = 0;

  control_unit_p #(.ADDR_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IR(IR), .MOC(MOC), .COND(COND),
    .MLS0(MLS0), .MLS1(MLS1), .CTL(CTL)
  );

  always #5 CLK = ~CLK;

  function automatic int start_of(input logic [31:0] ir);
    if (ir[27:25] == 3'b000 && !ir[4]) return 10;
    if (ir[27:25] == 3'b000 && ir[4] && !ir[7]) return 12;
    if (ir[27:25] == 3'b001) return 11;
    if (ir[27:25] == 3'b010) return 16;
    if (ir[27:25] == 3'b011) return 17;
    if (ir[27:25] == 3'b100) return 20;
    if (ir[27:25] == 3'b101) return 22;
    return 31;
  endfunction

  // Microprogram flow by state number; state 18 reaches 19 on either IR[20] value
  function automatic int next_of(input int s, input logic [31:0] ir, input logic moc, input logic cond);
    case (s)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return moc ? 4 : 3;
      4: return cond ? start_of(ir) : 5;
      16, 17: return 18;
      18: return 19;
      19: return moc ? 20 : 19;
      21: return moc ? 22 : 21;
      5, 10, 11, 12, 20, 22, 23, 24: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [33:0] ctl_of(input int s);
    case (s)
      1, 16, 17: return 34'h0_4000_0000;
      2, 19: return 34'h0_1800_0000;
      3: return 34'h0_3800_0000;
      4: return 34'h0_8000_0000;
      10, 11, 12: return 34'h3_0000_0000;
      20, 23, 24: return 34'h1_0000_0000;
      21: return 34'h0_0800_0000;
      default: return 34'h0;
    endcase
  endfunction

  task automatic step(input logic rn, input logic [31:0] ir, input logic moc, input logic cond);
    exp_t e;
    @(negedge CLK);
    RESET_N = rn;
    IR = ir;
    MOC = moc;
    COND = cond;
    MLS0 = 1'($urandom);
    MLS1 = 1'($urandom);
    st = rn ? next_of(st, ir, moc, cond) : 0;
    e.st = st;
    e.ctl = ctl_of(st);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (CTL === e.ctl) passed++;
        else $display("FAIL ctl state=%0d got=%h want=%h", e.st, CTL, e.ctl);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] ir_a, ir_b, ir_c, ir_d;
    ir_a = 32'hE1D45004;
    ir_b = 32'h05552E52;
    ir_c = 32'hE1D45004;
    ir_d = 32'h0E000000;
    repeat (2) step(1'b0, ir_a, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    chk("reset_nfield", 64'(dut.q[57:55]), 64'h2);
    chk("reset_ctl", 64'(CTL), 64'h0);
    chk("reset_incr", 64'(dut.incr), 64'h1);
    repeat (6) step(1'b1, ir_a, 1'b0, 1'b1);
    step(1'b1, ir_a, 1'b1, 1'b1);
    repeat (2) step(1'b1, ir_a, 1'b0, 1'b1);
    repeat (2) step(1'b1, ir_b, 1'b0, 1'b1);
    step(1'b1, ir_b, 1'b1, 1'b1);
    repeat (4) step(1'b1, ir_b, 1'b0, 1'b1);
    step(1'b1, ir_b, 1'b1, 1'b1);
    step(1'b1, ir_b, 1'b0, 1'b1);
    repeat (2) step(1'b1, ir_c, 1'b0, 1'b0);
    step(1'b1, ir_c, 1'b1, 1'b0);
    repeat (2) step(1'b1, ir_c, 1'b0, 1'b0);
    repeat (2) step(1'b1, ir_d, 1'b0, 1'b1);
    step(1'b1, ir_d, 1'b1, 1'b1);
    repeat (3) step(1'b1, ir_d, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) >= 2, $urandom, $urandom_range(3) == 0, $urandom_range(3) != 0);
    repeat (2) @(posedge CLK);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
